// File: rtl/weight_stream_loader_pkg.sv
// Shared definitions for the weight loading path: FSM state encoding and
// default widths also used by the WeightBuffer and layer-control blocks.
package weight_stream_loader_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_LEN = 9;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/weight_stream_loader_if.sv
// Stream input and WeightBuffer write port of the weight loader.
//
// Handshakes:
//   stream  : a word moves in a cycle where s_valid && s_ready at the rising
//             edge; while s_valid is high and not taken, the source holds
//             s_data stable.
//   write   : wr_en is only high when wr_ready is high; every cycle with
//             wr_en high is one write of data_wr to wr_addr.
interface weight_stream_loader_if
    import weight_stream_loader_pkg::*;
#(
    parameter int DW = weight_stream_loader_pkg::DATA_W,
    parameter int AW = weight_stream_loader_pkg::ADDR_LEN
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] data_wr;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          wr_ready;

    // Environment side: DMA stream source and WeightBuffer write sink.
    modport master (
        output s_data, s_valid, wr_ready,
        input  s_ready, data_wr, wr_addr, wr_en
    );

    // Loader side.
    modport slave (
        input  s_data, s_valid, wr_ready,
        output s_ready, data_wr, wr_addr, wr_en
    );
endinterface

// File: rtl/weight_stream_loader_skid_fifo2.sv
// Two-entry FIFO with registered head; simultaneous push and pop is allowed
// whenever the FIFO is non-empty. Caller must not push when full or pop when
// empty.
module skid_fifo2 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [1:0]        occupancy
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign empty     = (count == 2'd0);
    assign occupancy = count;
endmodule

// File: rtl/weight_stream_loader.sv
// Loads a block of words from a DMA stream into the WeightBuffer write port,
// starting at a configured address, and pulses done when the last word is
// written.
module weight_stream_loader
    import weight_stream_loader_pkg::*;
#(
    parameter int DATA_W   = weight_stream_loader_pkg::DATA_W,
    parameter int ADDR_LEN = weight_stream_loader_pkg::ADDR_LEN,
    parameter int CNT_W    = weight_stream_loader_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  conf,
    input  logic [ADDR_LEN-1:0]   st_addr,
    input  logic [CNT_W-1:0]      word_num,
    weight_stream_loader_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output state_t                dbg_state
);
    state_t              state;
    state_t              state_next;
    logic [ADDR_LEN-1:0] addr_q;
    logic [CNT_W-1:0]    rem_acc;
    logic [CNT_W-1:0]    rem_wr;
    logic                err_q;
    logic                s_ready_c;
    logic                write_c;
    logic                accept;
    logic                fifo_empty;
    logic [1:0]          occupancy;
    logic [DATA_W-1:0]   head;

    assign accept = bus.s_valid && s_ready_c;

    skid_fifo2 #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (bus.s_data),
        .pop       (write_c),
        .head      (head),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus stream-ready and write-strobe decode.
    always_comb begin
        state_next = state;
        s_ready_c  = 1'b0;
        write_c    = 1'b0;
        case (state)
            IDLE: begin
                if (conf) begin
                    state_next = (word_num == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                s_ready_c = (occupancy != 2'd2) && (rem_acc != '0);
                write_c   = !fifo_empty && bus.wr_ready;
                if (bus.s_valid && s_ready_c && (rem_acc == CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                write_c = !fifo_empty && bus.wr_ready;
                if ((rem_wr == '0) || (write_c && (rem_wr == CNT_W'(1)))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address and remaining-word counters; loaded by conf in IDLE only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rem_acc <= '0;
            rem_wr  <= '0;
        end else if ((state == IDLE) && conf) begin
            addr_q  <= st_addr;
            rem_acc <= word_num;
            rem_wr  <= word_num;
        end else begin
            if (accept) begin
                rem_acc <= rem_acc - CNT_W'(1);
            end
            if (write_c) begin
                addr_q <= addr_q + ADDR_LEN'(1);
                rem_wr <= rem_wr - CNT_W'(1);
            end
        end
    end

    // Sticky configuration error: set by conf outside IDLE, cleared by a
    // conf that is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (conf) begin
            err_q <= (state != IDLE);
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.wr_en   = write_c;
    assign bus.data_wr = head;
    assign bus.wr_addr = addr_q;
    assign busy        = (state == LOAD) || (state == DRAIN);
    assign done        = (state == DONE);
    assign err_cfg     = err_q;
    assign dbg_state   = state;
endmodule
